iot_event_reporter: RTL and testbench

- Sits on the device side of the IoT activity-monitor interface and drives the monitor's change / on_off inputs.
- Samples a per-device status bitmap and detects each device's transitions against the state already reported.
- Serialises the transitions into one-per-cycle change pulses, so the downstream up/down counter tracks the number of active devices exactly.
- Uses round-robin arbitration so no device starves during bursts.

---
 rtl/iot_event_reporter.sv | 82 ++++++++
 tb/tb_iot_event_reporter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/iot_event_reporter.sv
// Device-side event reporter: synchronises a device status bitmap and serialises
// per-device transitions into round-robin change/on_off pulses for the activity monitor.
module iot_event_reporter #(
  parameter int unsigned N_DEV = 8,
  parameter int unsigned ID_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] dev_status,
  input  logic             enable,
  output logic             change,
  output logic             on_off,
  output logic [ID_W-1:0]  dev_id,
  output logic             pending
);

  logic [N_DEV-1:0] s1_q;
  logic [N_DEV-1:0] s2_q;
  logic [N_DEV-1:0] reported_q;
  logic [N_DEV-1:0] diff;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  ptr_next;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  scan_idx;
  logic             found;
  logic             change_q;
  logic             on_off_q;
  logic [ID_W-1:0]  dev_id_q;
  logic             pending_q;

  // Bits where the synchronised level differs from what the monitor has been told.
  assign diff = s2_q ^ reported_q;

  // Round-robin search: first set bit of diff at or above ptr, wrapping modulo N_DEV.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      scan_idx = ID_W'((32'(ptr_q) + i) % N_DEV);
      if (!found && diff[scan_idx]) begin
        found = 1'b1;
        grant = scan_idx;
      end
    end
  end

  assign ptr_next = (32'(grant) + 32'd1 == N_DEV) ? '0 : grant + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      reported_q <= '0;
      ptr_q      <= '0;
      change_q   <= 1'b0;
      on_off_q   <= 1'b0;
      dev_id_q   <= '0;
      pending_q  <= 1'b0;
    end else begin
      s1_q      <= dev_status;
      s2_q      <= s1_q;
      pending_q <= found;
      if (enable && found) begin
        change_q          <= 1'b1;
        on_off_q          <= s2_q[grant];
        dev_id_q          <= grant;
        reported_q[grant] <= s2_q[grant];
        ptr_q             <= ptr_next;
      end else begin
        // on_off and dev_id hold their last reported values.
        change_q <= 1'b0;
      end
    end
  end

  assign change  = change_q;
  assign on_off  = on_off_q;
  assign dev_id  = dev_id_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_iot_event_reporter.sv
// Scoreboard bench for iot_event_reporter: expected events are queued when stimulus is
// applied and popped by a monitor on every observed change pulse.
module tb_iot_event_reporter;

  localparam int unsigned N_DEV = 8;
  localparam int unsigned ID_W  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_DEV-1:0] dev_status;
  logic             enable;
  logic             change;
  logic             on_off;
  logic [ID_W-1:0]  dev_id;
  logic             pending;

  int unsigned sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          pulse_cnt = 0;
  int          model_cnt = 0;

  iot_event_reporter #(
    .N_DEV(N_DEV),
    .ID_W (ID_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dev_status(dev_status),
    .enable    (enable),
    .change    (change),
    .on_off    (on_off),
    .dev_id    (dev_id),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned ev(input logic on, input int unsigned id);
    return (32'(on) << ID_W) | id;
  endfunction

  // Monitor: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    int unsigned exp;
    if (change) begin
      pulse_cnt++;
      if (on_off) model_cnt++;
      else model_cnt--;
      exp = (sb.size() > 0) ? sb.pop_front() : 32'hFFFF;
      check("event", 32'({on_off, dev_id}), exp);
    end
  end

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !change && !pending) break;
    end
    check({"drain_", tag}, 32'(sb.size()), 32'd0);
    check({"idle_", tag}, 32'({change, pending}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    dev_status = '0;
    sb.delete();
    model_cnt  = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int target;
    rst        = 1'b1;
    enable     = 1'b1;
    dev_status = '0;

    // 1: reset values held throughout reset and just after release.
    repeat (20) begin
      @(negedge clk);
      check("rst_change", 32'(change), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      check("rst_dev_id", 32'(dev_id), 32'd0);
      check("rst_on_off", 32'(on_off), 32'd0);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_change", 32'(change), 32'd0);
    end

    // 2: single device on then off, with exact latency.
    sb.push_back(ev(1'b1, 3));
    dev_status = 8'h08;
    repeat (2) begin
      @(negedge clk);
      check("lat_on_early", 32'(change), 32'd0);
    end
    @(negedge clk);
    check("lat_on", 32'({change, on_off, dev_id}), 32'({1'b1, 1'b1, 3'd3}));
    @(negedge clk);
    check("single_on_once", 32'(change), 32'd0);
    drain("on3", 10);
    sb.push_back(ev(1'b0, 3));
    dev_status = 8'h00;
    repeat (2) @(negedge clk);
    @(negedge clk);
    check("lat_off", 32'({change, on_off, dev_id}), 32'({1'b1, 1'b0, 3'd3}));
    drain("off3", 10);

    // 3: full burst after reset, back-to-back.
    do_reset();
    for (int i = 0; i < 8; i++) sb.push_back(ev(1'b1, i));
    dev_status = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (change) break;
    end
    for (int i = 0; i < 8; i++) begin
      check("burst_b2b", 32'(change), 32'd1);
      @(negedge clk);
    end
    check("burst_end_change", 32'(change), 32'd0);
    check("burst_end_pending", 32'(pending), 32'd0);
    check("burst_count", 32'(model_cnt), 32'd8);

    // 4: round-robin fairness starting from ptr=6.
    for (int i = 0; i < 8; i++) sb.push_back(ev(1'b0, i));
    dev_status = 8'h00;
    drain("all_off", 30);
    sb.push_back(ev(1'b1, 5));
    dev_status = 8'h20;
    drain("on5", 10);
    sb.push_back(ev(1'b1, 6));
    sb.push_back(ev(1'b1, 2));
    dev_status = 8'h64;
    drain("rr", 10);

    // 5: hold with enable=0, device 7 coalesces away.
    sb.push_back(ev(1'b0, 5));
    sb.push_back(ev(1'b0, 6));
    sb.push_back(ev(1'b0, 2));
    dev_status = 8'h00;
    drain("rr_off", 12);
    enable     = 1'b0;
    base       = pulse_cnt;
    dev_status = 8'h81;
    repeat (5) @(negedge clk);
    dev_status = 8'h01;
    repeat (5) @(negedge clk);
    check("hold_no_pulse", 32'(pulse_cnt - base), 32'd0);
    check("hold_pending", 32'(pending), 32'd1);
    sb.push_back(ev(1'b1, 0));
    enable = 1'b1;
    drain("coalesce", 10);
    check("coalesce_one", 32'(pulse_cnt - base), 32'd1);

    // 6: reset after the third pulse of a burst.
    do_reset();
    for (int i = 0; i < 8; i++) sb.push_back(ev(1'b1, i));
    dev_status = 8'hFF;
    target     = pulse_cnt + 3;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (pulse_cnt >= target) break;
    end
    check("mid_three", 32'(pulse_cnt >= target), 32'd1);
    check("mid_model", 32'(model_cnt), 32'd3);
    rst = 1'b1;
    sb.delete();
    model_cnt = 0;
    base      = pulse_cnt;
    repeat (4) begin
      @(negedge clk);
      check("mid_rst_change", 32'(change), 32'd0);
    end
    check("mid_rst_pulses", 32'(pulse_cnt - base), 32'd0);
    for (int i = 0; i < 8; i++) sb.push_back(ev(1'b1, i));
    rst = 1'b0;
    drain("after_rst", 30);
    check("after_rst_pulses", 32'(pulse_cnt - base), 32'd8);
    check("after_rst_model", 32'(model_cnt), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
